// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared definitions for the serial pattern generator.
//   - default widths for the generator parameters
//   - FSM state encoding (legacy-compatible localparam constants)
//   - pattern-length clamp helper
package seq_gen_pkg;

    // Default widths; the top-level parameters take these as defaults.
    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_LEN_W   = 4;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_GAP_W   = 3;

    // FSM state encoding.
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t GAP   = 2'd2;
    localparam state_t DONE  = 2'd3;

    // Lengths beyond the widest supported pattern fall back to that width.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        if (len > max_len) begin
            clamp_len = max_len;
        end else begin
            clamp_len = len;
        end
    endfunction

endpackage

// File: rtl/seq_gen_shreg.sv
// seq_gen_shreg: shadow pattern, output shift register and bit index.
//   The pattern is stored left-justified so the bit to transmit always sits
//   in the MSB; shifting left fills with zeros, so once a pass is complete
//   the output bit is 0 without extra gating.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   clear           drop the shift register and index (idle / abort)
//   load            capture pattern/len into the shadow and start a pass
//   reload          restart a pass from the shadow copy
//   shift           advance one bit
//   pattern, len    new configuration (len already clamped, 1..MAX_LEN)
//   bit_out         current serial bit (register output)
//   last_bit        current index is 0
//   last_next       index after this edge will be 0 (SEQGEN_MARK_EN only)
module seq_gen_shreg
    import seq_gen_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               load,
    input  logic               reload,
    input  logic               shift,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               bit_out,
    output logic               last_bit
`ifdef SEQGEN_MARK_EN
    ,
    output logic               last_next
`endif
);

    logic [MAX_LEN-1:0] pat_r;
    logic [MAX_LEN-1:0] sh_r;
    logic [MAX_LEN-1:0] aligned_s;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   idx_r;

    // Left-justify the low len bits of pattern so bit len-1 lands in the MSB.
    always_comb begin
        aligned_s = {MAX_LEN{1'b0}};
        for (int j = 0; j < MAX_LEN; j++) begin
            if (j < int'(len)) begin
                aligned_s[MAX_LEN-1-j] = pattern[int'(len)-1-j];
            end else begin
                aligned_s[MAX_LEN-1-j] = 1'b0;
            end
        end
    end

    // Shadow pattern, shift register and down-counting bit index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_r <= {MAX_LEN{1'b0}};
            sh_r  <= {MAX_LEN{1'b0}};
            len_r <= {LEN_W{1'b0}};
            idx_r <= {LEN_W{1'b0}};
        end else if (clear) begin
            sh_r  <= {MAX_LEN{1'b0}};
            idx_r <= {LEN_W{1'b0}};
        end else if (load) begin
            pat_r <= aligned_s;
            sh_r  <= aligned_s;
            len_r <= len;
            idx_r <= len - LEN_W'(1);
        end else if (reload) begin
            sh_r  <= pat_r;
            idx_r <= len_r - LEN_W'(1);
        end else if (shift) begin
            sh_r <= {sh_r[MAX_LEN-2:0], 1'b0};
            if (idx_r != {LEN_W{1'b0}}) begin
                idx_r <= idx_r - LEN_W'(1);
            end else begin
                idx_r <= idx_r;
            end
        end else begin
            sh_r  <= sh_r;
            idx_r <= idx_r;
        end
    end

    assign bit_out  = sh_r[MAX_LEN-1];
    assign last_bit = (idx_r == {LEN_W{1'b0}});

`ifdef SEQGEN_MARK_EN
    // Look-ahead of last_bit so the registered mark lines up with bit 0.
    always_comb begin
        if (clear) begin
            last_next = 1'b0;
        end else if (load) begin
            last_next = (len == LEN_W'(1));
        end else if (reload) begin
            last_next = (len_r == LEN_W'(1));
        end else if (shift) begin
            last_next = (idx_r == LEN_W'(1));
        end else begin
            last_next = (idx_r == {LEN_W{1'b0}});
        end
    end
`endif

endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial pattern transmitter feeding a detector's in_seq.
//   Sends pattern[pat_len-1:0] MSB-first, rep_cnt times, with gap_len zero
//   bits between repetitions. All outputs are registered.
// Optional feature macro: SEQGEN_MARK_EN adds output 'mark', high with the
//   last bit of every repetition.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           begin a run (sampled only in IDLE)
//   abort           synchronous abort to IDLE, no done pulse
//   pattern, pat_len, rep_cnt, gap_len   run configuration, latched on start
//   ser_out         serial data
//   ser_valid       ser_out carries a pattern bit
//   busy            first pattern bit through last pattern bit, gaps included
//   done            one-cycle pulse after the last bit of the last repetition
//   mark            last bit of each repetition (SEQGEN_MARK_EN only)
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int GAP_W   = DEF_GAP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic [CNT_W-1:0]   rep_cnt,
    input  logic [GAP_W-1:0]   gap_len,
    output logic               ser_out,
    output logic               ser_valid,
    output logic               busy,
    output logic               done
`ifdef SEQGEN_MARK_EN
    ,
    output logic               mark
`endif
);

    state_t             state_r, next_state_s;
    logic [CNT_W-1:0]   rep_r, rep_next_s;
    logic [GAP_W-1:0]   gap_len_r, gap_len_next_s;
    logic [GAP_W-1:0]   gap_cnt_r, gap_cnt_next_s;
    logic [LEN_W-1:0]   len_eff_s;
    logic               load_s, reload_s, shift_s, clear_s;
    logic               bit_out_s, last_bit_s;
    logic               ser_valid_r, busy_r, done_r;

    assign len_eff_s = LEN_W'(clamp_len(32'(pat_len), MAX_LEN));

    seq_gen_shreg #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear_s),
        .load     (load_s),
        .reload   (reload_s),
        .shift    (shift_s),
        .pattern  (pattern),
        .len      (len_eff_s),
        .bit_out  (bit_out_s),
        .last_bit (last_bit_s)
`ifdef SEQGEN_MARK_EN
        ,
        .last_next (last_next_s)
`endif
    );

`ifdef SEQGEN_MARK_EN
    logic last_next_s;
    logic mark_r;
`endif

    // Next-state, repetition/gap counter and shift-register control.
    always_comb begin
        next_state_s   = state_r;
        rep_next_s     = rep_r;
        gap_len_next_s = gap_len_r;
        gap_cnt_next_s = gap_cnt_r;
        load_s         = 1'b0;
        reload_s       = 1'b0;
        shift_s        = 1'b0;
        clear_s        = 1'b0;
        if (abort) begin
            next_state_s   = IDLE;
            rep_next_s     = {CNT_W{1'b0}};
            gap_cnt_next_s = {GAP_W{1'b0}};
            clear_s        = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    clear_s = 1'b1;
                    if (start) begin
                        gap_len_next_s = gap_len;
                        gap_cnt_next_s = {GAP_W{1'b0}};
                        if ((len_eff_s == {LEN_W{1'b0}}) || (rep_cnt == {CNT_W{1'b0}})) begin
                            next_state_s = DONE;
                            rep_next_s   = {CNT_W{1'b0}};
                        end else begin
                            next_state_s = SHIFT;
                            rep_next_s   = rep_cnt;
                            load_s       = 1'b1;
                            clear_s      = 1'b0;
                        end
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                SHIFT: begin
                    if (!last_bit_s) begin
                        shift_s = 1'b1;
                    end else if (rep_r > CNT_W'(1)) begin
                        // The repetition count only ever reaches 1 here, so it cannot wrap.
                        rep_next_s = rep_r - CNT_W'(1);
                        if (gap_len_r != {GAP_W{1'b0}}) begin
                            next_state_s   = GAP;
                            gap_cnt_next_s = gap_len_r;
                            shift_s        = 1'b1;
                        end else begin
                            reload_s = 1'b1;
                        end
                    end else begin
                        next_state_s = DONE;
                        rep_next_s   = {CNT_W{1'b0}};
                        shift_s      = 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt_r <= GAP_W'(1)) begin
                        next_state_s   = SHIFT;
                        gap_cnt_next_s = {GAP_W{1'b0}};
                        reload_s       = 1'b1;
                    end else begin
                        gap_cnt_next_s = gap_cnt_r - GAP_W'(1);
                        shift_s        = 1'b1;
                    end
                end
                DONE: begin
                    next_state_s = IDLE;
                    clear_s      = 1'b1;
                end
                default: begin
                    next_state_s = IDLE;
                    clear_s      = 1'b1;
                end
            endcase
        end
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            rep_r       <= {CNT_W{1'b0}};
            gap_len_r   <= {GAP_W{1'b0}};
            gap_cnt_r   <= {GAP_W{1'b0}};
            ser_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            rep_r       <= rep_next_s;
            gap_len_r   <= gap_len_next_s;
            gap_cnt_r   <= gap_cnt_next_s;
            ser_valid_r <= (next_state_s == SHIFT);
            busy_r      <= (next_state_s == SHIFT) || (next_state_s == GAP);
            done_r      <= (next_state_s == DONE);
        end
    end

`ifdef SEQGEN_MARK_EN
    // Mark register: high alongside bit 0 of every repetition.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mark_r <= 1'b0;
        end else begin
            mark_r <= (next_state_s == SHIFT) && last_next_s;
        end
    end

    assign mark = mark_r;
`endif

    assign ser_out   = bit_out_s;
    assign ser_valid = ser_valid_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule
